lifo_stack: RTL
===============

// Module: lifo_stack
// PURPOSE
//  Stack (last-in-first-out) buffer, the reverse-order counterpart of the team's fifo.
//  Same valid/ready stream interface on both sides, so it drops into any stream path.
//  Used where data must come back out in reverse order: descriptor return, bit/byte
//  reversal, undo history. Concurrent push and pop are supported.
// PARAMETERS
//  WIDTH  8  data bit width
//  DEPTH  8  number of entries (>=2); LVL_W = $clog2(DEPTH+1)
// PORTS
//  clk       in   1      clock; all state updates on rising edge
//  rst       in   1      synchronous reset, active-high
//  in_data   in   WIDTH  push data
//  in_valid  in   1      push request
//  in_ready  out  1      stack can accept push this cycle
//  out_data  out  WIDTH  top-of-stack data
//  out_valid out  1      top-of-stack valid
//  out_ready in   1      pop request
//  level     out  LVL_W  number of stored entries, 0..DEPTH
//  full      out  1      level == DEPTH
//  empty     out  1      level == 0
//  flush     in   1      only present with LIFO_FLUSH_EN
// BEHAVIOUR
//  - Storage mem[0..DEPTH-1]; stack pointer sp == level; top entry is mem[sp-1].
//  - Reset: sp=0 -> level=0, empty=1, full=0, out_valid=in_valid, in_ready=1.
//    mem contents are not reset. Reset overrides any push/pop in the same cycle.
//  - push = in_valid & in_ready; pop = out_valid & out_ready (transfer on clk edge).
//  - in_ready  = !full | out_ready   (full: push allowed only with concurrent pop)
//  - out_valid = !empty | in_valid   (empty: pop allowed only via bypass)
//    Neither expression uses the other output, so there is no combinational loop.
//  - out_data = empty ? in_data : mem[sp-1]. Combinational; a pushed word is visible
//    at out_data the next cycle (1-cycle latency); bypass when empty is 0 latency.
//  - Cycle update, exclusive cases:
//    push only : mem[sp] <= in_data; sp <= sp+1
//    pop only  : sp <= sp-1
//    push+pop, !empty : old top is popped, mem[sp-1] <= in_data (replace top); sp unchanged
//    push+pop, empty  : in_data passes straight through; mem and sp unchanged
//    neither   : no change
//  - Order rule: a word arriving in the same cycle as a pop is newer than the popped top.
//  - sp never leaves 0..DEPTH; no wrap-around. Arithmetic is on LVL_W bits.
//  - No overflow or underflow is possible through the handshake. A push while full
//    without a pop simply stalls (in_ready=0).
//  - Mid-operation rst: all pending state is discarded; the stack is empty next cycle.
// CONFIGURATION
//  LIFO_FLUSH_EN defined: adds port flush (in, 1). flush=1 gates in_ready=0 and
//    out_valid=0 that cycle (no transfers) and sets sp<=0. Stack is empty next cycle.
//    rst has priority over flush.
//  LIFO_FLUSH_EN undefined: no flush port; the stack is emptied only by pops or rst.
// TESTING
//  1 rst, then push 0x11,0x22,0x33 with out_ready=0 -> level=3; pop x3 -> 0x33,0x22,0x11; empty=1
//  2 push 8 words 0xA0..0xA7 (DEPTH=8) -> full=1, in_ready=0 while out_ready=0; 9th word
//    is held until out_ready=1, then pop 0xA7 and push the 9th in the same cycle; level stays 8
//  3 empty, in_valid=1 in_data=0x5C, out_ready=1 -> out_valid=1 out_data=0x5C same
//    cycle; level stays 0
//  4 stack holds 0x01,0x02; push 0x03 with concurrent pop -> pops 0x02; level=2;
//    next out_data=0x03, then 0x01
//  5 level=5, assert rst during a push -> next cycle level=0, empty=1, out_valid=in_valid
//  6 LIFO_FLUSH_EN: level=4, flush=1 with in_valid=out_ready=1 -> no transfer,
//    in_ready=out_valid=0 that cycle; next cycle level=0

Source files
------------

// File: rtl/lifo_stack.sv
// lifo_stack: valid/ready last-in-first-out buffer with concurrent push/pop and empty bypass.
// Define LIFO_FLUSH_EN to add a synchronous flush input that empties the stack.
module lifo_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
`ifdef LIFO_FLUSH_EN
  input  logic             flush,
`endif
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);

  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Handshake: a word moves on the rising edge when valid and ready are both high
  // on that side; ready/valid here never depend on the opposite side's output.
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [LVL_W-1:0]  sp_q;
  logic [LVL_W-1:0]  sp_d;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] top_addr;
  logic              flush_w;
  logic              push;
  logic              pop;

`ifdef LIFO_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  assign empty     = (sp_q == '0);
  assign full      = (sp_q == LVL_W'(DEPTH));
  assign level     = sp_q;
  assign top_addr  = ADDR_W'(sp_q - LVL_W'(1));
  assign in_ready  = !flush_w && (!full || out_ready);
  assign out_valid = !flush_w && (!empty || in_valid);
  assign out_data  = empty ? in_data : mem_q[top_addr];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    sp_d    = sp_q;
    wr_en   = 1'b0;
    wr_addr = ADDR_W'(sp_q);
    if (flush_w) begin
      sp_d = '0;
    end else if (push && pop) begin
      // The incoming word is newer than the popped top, so it takes that slot.
      // When empty it was handed straight through and nothing is stored.
      if (!empty) begin
        wr_en   = 1'b1;
        wr_addr = top_addr;
      end
    end else if (push) begin
      wr_en = 1'b1;
      sp_d  = sp_q + LVL_W'(1);
    end else if (pop) begin
      sp_d = sp_q - LVL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q <= '0;
    end else begin
      sp_q <= sp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem_q[wr_addr] <= in_data;
    end
  end

endmodule
